// File: rtl/mp_serial_adder_if.sv
// rtl/mp_serial_adder_if.sv - operand/result handshake bundle for mp_serial_adder
// Optional subtract input present when MP_ADDER_SUB_EN is defined.
`ifndef WIDTH
`define WIDTH 8
`endif

interface mp_serial_adder_if #(
    parameter int WIDTH = `WIDTH,
    parameter int LIMBS = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH*LIMBS-1:0] a;
    logic [WIDTH*LIMBS-1:0] b;
`ifdef MP_ADDER_SUB_EN
    logic                   sub;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH*LIMBS:0]   sum;

`ifdef MP_ADDER_SUB_EN
    modport master (output in_valid, a, b, sub, out_ready, input in_ready, out_valid, sum);
    modport slave  (input in_valid, a, b, sub, out_ready, output in_ready, out_valid, sum);
`else
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, sum);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, sum);
`endif
endinterface

// File: rtl/mp_serial_adder.sv
// rtl/mp_serial_adder.sv - multi-precision adder reusing one WIDTH-bit limb adder over LIMBS cycles
// Define MP_ADDER_SUB_EN to add a captured sub input computing a + ~b + 1.
`ifndef WIDTH
`define WIDTH 8
`endif

module mp_serial_adder #(
    parameter int WIDTH = `WIDTH,
    parameter int LIMBS = 4
) (
    input  logic              clk,
    input  logic              rst,
    mp_serial_adder_if.slave  bus
);
    localparam int N  = WIDTH * LIMBS;
    localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IW-1:0] LAST = IW'(LIMBS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [N-1:0]     a_r;
    logic [N-1:0]     b_r;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [N:0]       sum_r;
    logic             out_valid_r;
    logic [WIDTH:0]   limb;
    logic [N-1:0]     b_in;
    logic             carry_in;

    always_comb begin
        limb = {1'b0, a_r[int'(idx)*WIDTH +: WIDTH]}
             + {1'b0, b_r[int'(idx)*WIDTH +: WIDTH]}
             + {{WIDTH{1'b0}}, carry};
    end

`ifdef MP_ADDER_SUB_EN
    // Subtraction is two's complement: invert b and seed the carry chain with 1.
    assign b_in     = bus.sub ? ~bus.b : bus.b;
    assign carry_in = bus.sub;
`else
    assign b_in     = bus.b;
    assign carry_in = 1'b0;
`endif

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            sum_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        b_r   <= b_in;
                        carry <= carry_in;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r[int'(idx)*WIDTH +: WIDTH] <= limb[WIDTH-1:0];
                    carry <= limb[WIDTH];
                    if (idx == LAST) begin
                        sum_r[N]    <= limb[WIDTH];
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mp_serial_adder.sv
// tb/tb_mp_serial_adder.sv - directed self-checking bench for mp_serial_adder (WIDTH=8, LIMBS=4)
`timescale 1ns/1ps
module tb_mp_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    mp_serial_adder_if #(.WIDTH(8), .LIMBS(4)) bus ();

    mp_serial_adder #(.WIDTH(8), .LIMBS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check({tag, "_ready_timeout"}, 64'(bus.in_ready), 64'd1);
    endtask

    // Accepts one operand pair, scrambles the inputs afterwards, and checks latency and result.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [32:0] exp);
        int lat = 0;
        bus.a = av;
        bus.b = bv;
        bus.in_valid = 1'b1;
        wait_ready(tag);
        tick();
        bus.in_valid = 1'b0;
        bus.a = ~av;
        bus.b = ~bv;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_sum"}, 64'(bus.sum), 64'(exp));
    endtask

    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [32:0] vs [3];
    int          acc [3];

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
`ifdef MP_ADDER_SUB_EN
        bus.sub       = 1'b0;
`endif
        tick();
        tick();
        check("reset_in_ready", 64'(bus.in_ready), 64'd0);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_sum", 64'(bus.sum), 64'd0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

        run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
        tick();
        check("ripple_out_valid_drop", 64'(bus.out_valid), 64'd0);
        check("ripple_in_ready_back", 64'(bus.in_ready), 64'd1);

        run_op("nocarry", 32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789);
        tick();

        bus.out_ready = 1'b0;
        run_op("bp", 32'hF000_0000, 32'h2000_0001, 33'h1_1000_0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp_hold%0d_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp_hold%0d_sum", i), 64'(bus.sum), 64'h1_1000_0001);
            check($sformatf("bp_hold%0d_in_ready", i), 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);

        bus.a = 32'hFFFF_FFFF;
        bus.b = 32'hFFFF_FFFF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_sum", 64'(bus.sum), 64'd0);
        rst = 1'b0;
        run_op("after_rst", 32'h0000_0003, 32'h0000_0004, 33'h0_0000_0007);
        tick();

        va[0] = 32'h00FF_00FF; vb[0] = 32'h0001_0001; vs[0] = 33'h0_0100_0100;
        va[1] = 32'h7FFF_FFFF; vb[1] = 32'h0000_0001; vs[1] = 33'h0_8000_0000;
        va[2] = 32'hAAAA_AAAA; vb[2] = 32'h5555_5555; vs[2] = 33'h0_FFFF_FFFF;
        bus.a = va[0];
        bus.b = vb[0];
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int n = 0;
            wait_ready($sformatf("b2b%0d", i));
            tick();
            acc[i] = cyc;
            bus.a = 32'hFFFF_FFFF;
            bus.b = 32'hFFFF_FFFF;
            while (!bus.out_valid && n < 20) begin
                tick();
                n++;
            end
            check($sformatf("b2b%0d_sum", i), 64'(bus.sum), 64'(vs[i]));
            if (i < 2) begin
                bus.a = va[i+1];
                bus.b = vb[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        check("b2b_period_01", 64'(acc[1] - acc[0]), 64'd6);
        check("b2b_period_12", 64'(acc[2] - acc[1]), 64'd6);
        tick();

`ifdef MP_ADDER_SUB_EN
        bus.sub = 1'b1;
        run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 33'h0_FFFF_FFFE);
        tick();
        run_op("sub_noborrow", 32'h0000_0007, 32'h0000_0005, 33'h1_0000_0002);
        tick();
        bus.sub = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
